// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the core's single memory port between the instruction-fetch requester
// (instr_*) and the load/store requester (data_*). One transaction is in flight
// at a time. The memory-side request (mem_req_o and its address/controls) is
// fully registered; grants, response valids and response data back to the
// requesters are combinational so a requester sees its answer in the same
// cycle the memory produces it.
//
// Data accesses win arbitration by default. A 4-bit starvation counter tracks
// data grants made while a fetch was waiting; once it reaches STARVE_LIMIT the
// next contended grant goes to fetch.
//
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   instr_req_i / instr_addr_i     fetch request and byte address
//   instr_gnt_o                    fetch accepted (only ever in IDLE)
//   instr_rvalid_o / instr_rdata_o fetch response, data zero unless valid
//   data_req_i/_we_i/_be_i/_addr_i/_wdata_i   load/store request
//   data_gnt_o                     load/store accepted (only ever in IDLE)
//   data_rvalid_o / data_rdata_o   load/store response, data zero unless valid
//   mem_req_o/_we_o/_be_o/_addr_o/_wdata_o    registered memory request
//   mem_gnt_i / mem_rvalid_i / mem_rdata_i    memory accept and response
//   fetch_stall_o / data_stall_o   requester must hold its pipeline stage
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int MEM_ADDR_WIDTH = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int STARVE_LIMIT   = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,

  input  logic                      instr_req_i,
  input  logic [MEM_ADDR_WIDTH-1:0] instr_addr_i,
  output logic                      instr_gnt_o,
  output logic                      instr_rvalid_o,
  output logic [DATA_WIDTH-1:0]     instr_rdata_o,

  input  logic                      data_req_i,
  input  logic                      data_we_i,
  input  logic [DATA_WIDTH/8-1:0]   data_be_i,
  input  logic [MEM_ADDR_WIDTH-1:0] data_addr_i,
  input  logic [DATA_WIDTH-1:0]     data_wdata_i,
  output logic                      data_gnt_o,
  output logic                      data_rvalid_o,
  output logic [DATA_WIDTH-1:0]     data_rdata_o,

  output logic                      mem_req_o,
  output logic                      mem_we_o,
  output logic [DATA_WIDTH/8-1:0]   mem_be_o,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0]     mem_wdata_o,
  input  logic                      mem_gnt_i,
  input  logic                      mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]     mem_rdata_i,

  output logic                      fetch_stall_o,
  output logic                      data_stall_o
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;

  // Limit as a 4-bit value so it compares directly against the counter.
  localparam logic [3:0] STARVE_LIMIT_C = 4'(STARVE_LIMIT);
  localparam logic [3:0] STARVE_MAX_C   = 4'hF;

  localparam logic OWNER_DATA  = 1'b0;
  localparam logic OWNER_INSTR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                    state_r;
  state_t                    state_next_s;
  logic                      owner_r;
  logic [3:0]                starve_cnt_r;

  logic                      mem_req_r;
  logic                      mem_we_r;
  logic [BE_WIDTH-1:0]       mem_be_r;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr_r;
  logic [DATA_WIDTH-1:0]     mem_wdata_r;

  logic                      grant_open_s;
  logic                      sel_instr_s;
  logic                      instr_gnt_s;
  logic                      data_gnt_s;
  logic                      resp_fire_s;
  logic                      instr_rvalid_s;
  logic                      data_rvalid_s;
  logic [DATA_WIDTH-1:0]     instr_rdata_s;
  logic [DATA_WIDTH-1:0]     data_rdata_s;
  logic                      fetch_stall_s;
  logic                      data_stall_s;

  // Arbitration: pick a winner and raise exactly one grant while idle.
  always_comb begin
    grant_open_s = 1'b0;
    sel_instr_s  = 1'b0;
    instr_gnt_s  = 1'b0;
    data_gnt_s   = 1'b0;

    // rst_n is included so a request held during reset is not granted even
    // though the state register reads IDLE.
    if ((state_r == ST_IDLE) && rst_n) begin
      grant_open_s = 1'b1;
    end else begin
      grant_open_s = 1'b0;
    end

    // Fetch wins only when data is absent or fetch has been starved long enough.
    if (instr_req_i && (!data_req_i || (starve_cnt_r == STARVE_LIMIT_C))) begin
      sel_instr_s = 1'b1;
    end else begin
      sel_instr_s = 1'b0;
    end

    if (grant_open_s) begin
      instr_gnt_s = instr_req_i & sel_instr_s;
      data_gnt_s  = data_req_i & ~sel_instr_s;
    end else begin
      instr_gnt_s = 1'b0;
      data_gnt_s  = 1'b0;
    end
  end

  // Next-state logic of the transaction FSM.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (instr_gnt_s || data_gnt_s) begin
          state_next_s = ST_REQ;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        // A same-cycle mem_rvalid_i is ignored here; only the grant counts.
        if (mem_gnt_i) begin
          state_next_s = ST_RESP;
        end else begin
          state_next_s = ST_REQ;
        end
      end
      ST_RESP: begin
        if (mem_rvalid_i) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_RESP;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State, owner and starvation counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      owner_r      <= OWNER_DATA;
      starve_cnt_r <= 4'd0;
    end else begin
      state_r <= state_next_s;

      if (instr_gnt_s) begin
        owner_r <= OWNER_INSTR;
      end else if (data_gnt_s) begin
        owner_r <= OWNER_DATA;
      end else begin
        owner_r <= owner_r;
      end

      // Count data grants that left a fetch waiting; any fetch grant clears.
      if (instr_gnt_s) begin
        starve_cnt_r <= 4'd0;
      end else if (data_gnt_s && instr_req_i && (starve_cnt_r != STARVE_MAX_C)) begin
        starve_cnt_r <= starve_cnt_r + 4'd1;
      end else begin
        starve_cnt_r <= starve_cnt_r;
      end
    end
  end

  // Memory-side request registers: loaded on a grant, held until accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_be_r    <= {BE_WIDTH{1'b0}};
      mem_addr_r  <= {MEM_ADDR_WIDTH{1'b0}};
      mem_wdata_r <= {DATA_WIDTH{1'b0}};
    end else begin
      if (instr_gnt_s) begin
        // Fetches are always full-width reads.
        mem_req_r   <= 1'b1;
        mem_we_r    <= 1'b0;
        mem_be_r    <= {BE_WIDTH{1'b1}};
        mem_addr_r  <= instr_addr_i;
        mem_wdata_r <= {DATA_WIDTH{1'b0}};
      end else if (data_gnt_s) begin
        mem_req_r   <= 1'b1;
        mem_we_r    <= data_we_i;
        mem_be_r    <= data_be_i;
        mem_addr_r  <= data_addr_i;
        mem_wdata_r <= data_wdata_i;
      end else if ((state_r == ST_REQ) && mem_gnt_i) begin
        mem_req_r   <= 1'b0;
      end else begin
        mem_req_r   <= mem_req_r;
      end
    end
  end

  // Response routing to the owner, with data forced to zero when not valid.
  always_comb begin
    resp_fire_s    = (state_r == ST_RESP) & mem_rvalid_i;
    instr_rvalid_s = 1'b0;
    data_rvalid_s  = 1'b0;
    instr_rdata_s  = {DATA_WIDTH{1'b0}};
    data_rdata_s   = {DATA_WIDTH{1'b0}};

    if (resp_fire_s && (owner_r == OWNER_INSTR)) begin
      instr_rvalid_s = 1'b1;
      instr_rdata_s  = mem_rdata_i;
    end else if (resp_fire_s) begin
      data_rvalid_s = 1'b1;
      data_rdata_s  = mem_rdata_i;
    end else begin
      instr_rvalid_s = 1'b0;
      data_rvalid_s  = 1'b0;
    end
  end

  // Stall: waiting for a grant, or owning an unfinished transaction.
  always_comb begin
    fetch_stall_s = (instr_req_i & ~instr_gnt_s)
                  | ((owner_r == OWNER_INSTR) & (state_r != ST_IDLE) & ~instr_rvalid_s);
    data_stall_s  = (data_req_i & ~data_gnt_s)
                  | ((owner_r == OWNER_DATA) & (state_r != ST_IDLE) & ~data_rvalid_s);
  end

  assign instr_gnt_o    = instr_gnt_s;
  assign data_gnt_o     = data_gnt_s;
  assign instr_rvalid_o = instr_rvalid_s;
  assign data_rvalid_o  = data_rvalid_s;
  assign instr_rdata_o  = instr_rdata_s;
  assign data_rdata_o   = data_rdata_s;
  assign fetch_stall_o  = fetch_stall_s;
  assign data_stall_o   = data_stall_s;

  assign mem_req_o   = mem_req_r;
  assign mem_we_o    = mem_we_r;
  assign mem_be_o    = mem_be_r;
  assign mem_addr_o  = mem_addr_r;
  assign mem_wdata_o = mem_wdata_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Random fetch and load/store traffic against a memory responder with random
// grant and response latency plus occasional spurious mem_rvalid_i pulses.
// A reference model decides each grant from the arbitration rules, tracks a
// shadow memory image, and queues the expected memory request and response;
// separate monitor processes compare what the DUT presents.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int BW    = DW / 8;
  localparam int LIMIT = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          instr_req_i;
  logic [AW-1:0] instr_addr_i;
  logic          instr_gnt_o, instr_rvalid_o;
  logic [DW-1:0] instr_rdata_o;
  logic          data_req_i, data_we_i;
  logic [BW-1:0] data_be_i;
  logic [AW-1:0] data_addr_i;
  logic [DW-1:0] data_wdata_i;
  logic          data_gnt_o, data_rvalid_o;
  logic [DW-1:0] data_rdata_o;
  logic          mem_req_o, mem_we_o;
  logic [BW-1:0] mem_be_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic          mem_gnt_i, mem_rvalid_i;
  logic [DW-1:0] mem_rdata_i;
  logic          fetch_stall_o, data_stall_o;

  mem_port_arbiter #(
    .MEM_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
    .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
    .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
    .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .fetch_stall_o(fetch_stall_o), .data_stall_o(data_stall_o)
  );

  always #5 clk = ~clk;

  typedef struct { bit is_instr; bit is_store; logic [DW-1:0] data; } resp_t;
  typedef struct { bit we; logic [BW-1:0] be; logic [AW-1:0] addr; logic [DW-1:0] wdata; } mreq_t;

  int      tests = 0;
  int      fails = 0;
  resp_t   resp_q[$];
  mreq_t   mreq_q[$];
  bit      gnt_log[$];
  logic [DW-1:0] ref_mem[64];
  logic [DW-1:0] phy_mem[64];

  bit busy_m, owner_instr_m, i_taken, d_taken;
  int starve_m;
  bit resp_fire, resp_stale, rsp_phase;
  bit spur_en, go;
  int ipct, dpct;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name, input string what);
    tests++;
    fails++;
    $display("FAIL %s: %s (t=%0t)", name, what, $time);
  endtask

  function automatic logic [DW-1:0] init_word(input int i);
    logic [DW-1:0] w;
    w = 32'hC0DE_0000 ^ (DW'(i) * 32'h0101_0203);
    return w;
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] wd,
                                          input logic [BW-1:0] be);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < BW; b++) if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    return r;
  endfunction

  task automatic check_reset_outputs();
    check("rst_instr_gnt", 64'(instr_gnt_o), 64'd0);
    check("rst_data_gnt", 64'(data_gnt_o), 64'd0);
    check("rst_instr_rvalid", 64'(instr_rvalid_o), 64'd0);
    check("rst_data_rvalid", 64'(data_rvalid_o), 64'd0);
    check("rst_instr_rdata", 64'(instr_rdata_o), 64'd0);
    check("rst_data_rdata", 64'(data_rdata_o), 64'd0);
    check("rst_mem_req", 64'(mem_req_o), 64'd0);
    check("rst_mem_we", 64'(mem_we_o), 64'd0);
    check("rst_mem_be", 64'(mem_be_o), 64'd0);
    check("rst_mem_addr", 64'(mem_addr_o), 64'd0);
    check("rst_mem_wdata", 64'(mem_wdata_o), 64'd0);
    check("rst_fetch_stall", 64'(fetch_stall_o), 64'(instr_req_i));
    check("rst_data_stall", 64'(data_stall_o), 64'(data_req_i));
  endtask

  // Requesters + reference model: drive after posedge, predict/check at negedge.
  initial begin : model
    bit exp_i, exp_d, fire_ok;
    int idx;
    resp_t r;
    mreq_t m;
    wait (go);
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        instr_req_i = 1'b0; data_req_i = 1'b0;
        busy_m = 1'b0; starve_m = 0; owner_instr_m = 1'b0;
        i_taken = 1'b0; d_taken = 1'b0;
        resp_q.delete(); mreq_q.delete();
      end else begin
        if (!instr_req_i || i_taken) begin
          instr_req_i  = ($urandom_range(0, 99) < ipct);
          instr_addr_i = $urandom & 32'h0000_0FFC;
        end
        if (!data_req_i || d_taken) begin
          data_req_i   = ($urandom_range(0, 99) < dpct);
          data_we_i    = 1'($urandom_range(0, 1));
          data_be_i    = BW'($urandom_range(1, 15));
          data_addr_i  = $urandom & 32'h0000_0FFC;
          data_wdata_i = $urandom;
        end
        i_taken = 1'b0; d_taken = 1'b0;
      end
      @(negedge clk);
      if (!rst_n) begin
        check_reset_outputs();
      end else begin
        exp_i = 1'b0; exp_d = 1'b0;
        if (!busy_m && (instr_req_i || data_req_i)) begin
          if (instr_req_i && (!data_req_i || starve_m == LIMIT)) exp_i = 1'b1;
          else exp_d = 1'b1;
        end
        fire_ok = resp_fire && !resp_stale;
        check("instr_gnt", 64'(instr_gnt_o), 64'(exp_i));
        check("data_gnt", 64'(data_gnt_o), 64'(exp_d));
        check("fetch_stall", 64'(fetch_stall_o),
              64'((instr_req_i && !exp_i) || (busy_m && owner_instr_m && !fire_ok)));
        check("data_stall", 64'(data_stall_o),
              64'((data_req_i && !exp_d) || (busy_m && !owner_instr_m && !fire_ok)));
        if (fire_ok) busy_m = 1'b0;
        if (exp_i) begin
          idx = int'(instr_addr_i[7:2]);
          starve_m = 0; owner_instr_m = 1'b1; busy_m = 1'b1; i_taken = 1'b1;
          r.is_instr = 1'b1; r.is_store = 1'b0; r.data = ref_mem[idx];
          m.we = 1'b0; m.be = {BW{1'b1}}; m.addr = instr_addr_i; m.wdata = '0;
          resp_q.push_back(r); mreq_q.push_back(m); gnt_log.push_back(1'b1);
        end else if (exp_d) begin
          idx = int'(data_addr_i[7:2]);
          if (instr_req_i && starve_m < 15) starve_m++;
          owner_instr_m = 1'b0; busy_m = 1'b1; d_taken = 1'b1;
          r.is_instr = 1'b0; r.is_store = data_we_i; r.data = ref_mem[idx];
          m.we = data_we_i; m.be = data_be_i; m.addr = data_addr_i; m.wdata = data_wdata_i;
          resp_q.push_back(r); mreq_q.push_back(m); gnt_log.push_back(1'b0);
          if (data_we_i) ref_mem[idx] = merge(ref_mem[idx], data_wdata_i, data_be_i);
        end
      end
    end
  end

  // Memory responder: random grant/response latency, spurious rvalid pulses,
  // and a check of the registered request against the model's expectation.
  initial begin : responder
    int gnt_wait, rv_wait, idx;
    bit phase, drove_gnt;
    mreq_t cap, m;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    resp_fire = 1'b0; resp_stale = 1'b0; rsp_phase = 1'b0;
    phase = 1'b0; drove_gnt = 1'b0; gnt_wait = -1; rv_wait = 0;
    cap.we = 1'b0; cap.be = '0; cap.addr = '0; cap.wdata = '0;
    forever begin
      @(posedge clk); #1;
      if (resp_fire) begin phase = 1'b0; resp_stale = 1'b0; end
      if (drove_gnt) begin phase = 1'b1; rv_wait = $urandom_range(0, 3); end
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
      resp_fire = 1'b0; drove_gnt = 1'b0;
      if (!rst_n) begin
        if (phase) resp_stale = 1'b1;
        gnt_wait = -1;
      end else if (phase) begin
        if (rv_wait == 0) begin
          mem_rvalid_i = 1'b1; resp_fire = 1'b1;
          if (resp_stale || cap.we) mem_rdata_i = $urandom;
          else mem_rdata_i = phy_mem[int'(cap.addr[7:2])];
        end else begin
          rv_wait--;
        end
      end else begin
        if (mem_req_o) begin
          if (mreq_q.size() == 0) begin
            flag("mem_req_unexpected", "mem_req_o high with no granted transaction");
          end else begin
            m = mreq_q[0];
            check("mem_addr", 64'(mem_addr_o), 64'(m.addr));
            check("mem_we", 64'(mem_we_o), 64'(m.we));
            check("mem_be", 64'(mem_be_o), 64'(m.be));
            if (m.we) check("mem_wdata", 64'(mem_wdata_o), 64'(m.wdata));
          end
          if (gnt_wait < 0) gnt_wait = $urandom_range(0, 2);
          if (gnt_wait == 0) begin
            mem_gnt_i = 1'b1; drove_gnt = 1'b1; gnt_wait = -1;
            cap.we = mem_we_o; cap.be = mem_be_o; cap.addr = mem_addr_o; cap.wdata = mem_wdata_o;
            if (mreq_q.size() > 0) void'(mreq_q.pop_front());
            idx = int'(mem_addr_o[7:2]);
            if (mem_we_o) phy_mem[idx] = merge(phy_mem[idx], mem_wdata_o, mem_be_o);
          end else begin
            gnt_wait--;
          end
        end
        if (spur_en && $urandom_range(0, 7) == 0) begin
          mem_rvalid_i = 1'b1; mem_rdata_i = $urandom;
        end
      end
      rsp_phase = phase;
    end
  end

  // Response monitor: pops the scoreboard whenever a requester sees rvalid.
  initial begin : monitor
    resp_t r;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (!instr_rvalid_o) check("instr_rdata_gate", 64'(instr_rdata_o), 64'd0);
        if (!data_rvalid_o) check("data_rdata_gate", 64'(data_rdata_o), 64'd0);
        if (instr_rvalid_o || data_rvalid_o) begin
          if (!(resp_fire && !resp_stale) || resp_q.size() == 0) begin
            flag("unexpected_rvalid", $sformatf("instr_rvalid=%0b data_rvalid=%0b with no response due",
                 instr_rvalid_o, data_rvalid_o));
          end else begin
            r = resp_q.pop_front();
            check("rvalid_owner", 64'({instr_rvalid_o, data_rvalid_o}),
                  r.is_instr ? 64'd2 : 64'd1);
            if (!r.is_store) check("rdata", r.is_instr ? 64'(instr_rdata_o) : 64'(data_rdata_o),
                                   64'(r.data));
          end
        end else if (resp_fire && !resp_stale) begin
          flag("missing_rvalid", "memory responded but no requester rvalid");
          if (resp_q.size() > 0) void'(resp_q.pop_front());
        end
      end
    end
  end

  initial begin : main
    logic [9:0] order;
    bit found;
    rst_n = 1'b0;
    instr_req_i = 1'b0; instr_addr_i = '0;
    data_req_i = 1'b0; data_we_i = 1'b0; data_be_i = '0; data_addr_i = '0; data_wdata_i = '0;
    ipct = 0; dpct = 0; spur_en = 1'b0; go = 1'b0;
    busy_m = 1'b0; starve_m = 0; owner_instr_m = 1'b0; i_taken = 1'b0; d_taken = 1'b0;
    for (int i = 0; i < 64; i++) begin ref_mem[i] = init_word(i); phy_mem[i] = init_word(i); end

    // Reset state, then a request held during reset: stall follows, no grant.
    repeat (2) @(negedge clk);
    check_reset_outputs();
    instr_req_i = 1'b1;
    #1 check_reset_outputs();
    instr_req_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Spurious rvalid while idle must never reach a requester.
    spur_en = 1'b1;
    repeat (20) @(negedge clk);
    spur_en = 1'b0;
    repeat (2) @(negedge clk);

    // Both requesters continuously high from a fresh counter.
    gnt_log.delete();
    ipct = 100; dpct = 100; go = 1'b1;
    for (int c = 0; c < 400 && gnt_log.size() < 10; c++) @(negedge clk);
    if (gnt_log.size() < 10) begin
      flag("grant_order_timeout", $sformatf("only %0d grants seen", gnt_log.size()));
    end else begin
      for (int i = 0; i < 10; i++) order[i] = gnt_log[i];
      check("grant_order", 64'(order), 64'(10'b10_0001_0000));
    end

    // Mixed random traffic with wait states and spurious rvalid.
    ipct = 60; dpct = 60; spur_en = 1'b1;
    repeat (1500) @(negedge clk);

    // Reset while the memory is still to respond; its late rvalid is stale.
    found = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (rsp_phase && !resp_fire) begin found = 1'b1; break; end
    end
    if (!found) flag("reset_midop_timeout", "no transaction reached the response phase");
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    ipct = 100; dpct = 0;
    repeat (20) @(negedge clk);
    ipct = 55; dpct = 55;
    repeat (800) @(negedge clk);

    // Drain: every granted transaction must have been answered.
    ipct = 0; dpct = 0;
    repeat (40) @(negedge clk);
    check("drain_resp_q", 64'(resp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the core's single memory port between the instruction-fetch requester (IF) and the load/store requester (EX). Accepts one transaction at a time, drives a registered request/grant/rvalid handshake to memory, routes the response back to the owner, and raises per-requester stall lines for the pipeline control logic. Data accesses win by default. A starvation guard periodically forces a fetch grant.

## Interface
- MEM_ADDR_WIDTH, 32, byte address width of both requesters and the memory port
- DATA_WIDTH, 32, data bus width; byte-enable width is DATA_WIDTH/8
- STARVE_LIMIT, 4, consecutive data grants (with fetch waiting) before fetch is forced; legal range 1..15
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- instr_req_i / instr_addr_i  input  1 / MEM_ADDR_WIDTH  fetch request and its address
- instr_gnt_o / instr_rvalid_o / instr_rdata_o  output  1 / 1 / DATA_WIDTH  fetch accept, response valid, response data
- data_req_i / data_we_i / data_be_i / data_addr_i / data_wdata_i  input  1 / 1 / DATA_WIDTH/8 / MEM_ADDR_WIDTH / DATA_WIDTH  load/store request
- data_gnt_o / data_rvalid_o / data_rdata_o  output  1 / 1 / DATA_WIDTH  load/store accept, response valid, response data
- mem_req_o / mem_we_o / mem_be_o / mem_addr_o / mem_wdata_o  output  1 / 1 / DATA_WIDTH/8 / MEM_ADDR_WIDTH / DATA_WIDTH  memory request, all registered
- mem_gnt_i / mem_rvalid_i / mem_rdata_i  input  1 / 1 / DATA_WIDTH  memory accept, response valid, response data
- fetch_stall_o / data_stall_o  output  1 / 1  requester must hold its pipeline stage

## Operation
- FSM: IDLE, REQ, RESP. Owner register: INSTR or DATA.
- IDLE: if any req_i is high, select the owner, assert that requester's gnt_o combinationally, latch addr/we/be/wdata into the mem_*_o registers, set owner, go to REQ. Fetch is always latched with we=0 and be all ones.
- Selection: data wins, unless instr_req_i and data_req_i are both high and starve_cnt == STARVE_LIMIT; then instr wins.
- starve_cnt: increments (saturating) on each data grant made while instr_req_i is high. It clears to 0 on any instr grant. Width is 4 bits.
- REQ: mem_req_o = 1 with stable address and controls until mem_gnt_i; then go to RESP and deassert mem_req_o the next cycle.
- RESP: wait for mem_rvalid_i. In that cycle, the owner's rvalid_o = 1 and its rdata_o = mem_rdata_i (combinational); go to IDLE. Stores also complete on rvalid, and their rdata is don't-care.
- gnt_o is never asserted outside IDLE. Requesters keep req_i high until they see gnt_o.
- mem_rvalid_i in IDLE or REQ is ignored. The non-owner's rvalid_o is always 0.
- The rdata_o outputs are mem_rdata_i gated to zero when the corresponding rvalid_o is 0.
- fetch_stall_o = (instr_req_i & !instr_gnt_o) | (owner==INSTR & state!=IDLE & !instr_rvalid_o). data_stall_o is defined identically for the data requester.

## Timing
- Reset (async assert, sync release): state IDLE, owner DATA, starve_cnt 0, mem_req_o/mem_we_o 0, mem_be_o/mem_addr_o/mem_wdata_o 0. All gnt/rvalid/rdata outputs are 0. Stalls follow req_i combinationally.
- Minimum transaction: grant at cycle T, mem_req_o at T+1, mem_gnt_i at T+1, mem_rvalid_i at T+2 (owner rvalid_o at T+2), IDLE at T+3, next grant earliest at T+3. Throughput is one transaction per 3 cycles.
- Each memory wait-state cycle in REQ or RESP adds one cycle. There is no timeout.
- Simultaneous requests at a grant: exactly one gnt_o is asserted. The loser's stall stays high.
- Reset mid-transaction: the FSM is abandoned immediately. A late mem_rvalid_i after reset arrives in IDLE and is ignored.
- mem_gnt_i and mem_rvalid_i in the same cycle while in REQ: only gnt is honoured. The memory must present rvalid no earlier than the cycle after gnt.

## Test plan
- Single load: data_req_i=1, data_addr_i=0x100, mem grants immediately and returns 0xDEADBEEF the next cycle -> data_gnt_o at T, mem_addr_o=0x100 with mem_req_o at T+1, data_rvalid_o=1 with data_rdata_o=0xDEADBEEF at T+2, data_stall_o low at T+2.
- Store: we=1, be=4'b0011, wdata=0x1234ABCD, addr=0x40 -> mem_we_o=1, mem_be_o=0011, mem_wdata_o=0x1234ABCD held through 3 REQ wait cycles; data_rvalid_o pulses on mem_rvalid_i.
- Contention: both requesters held high continuously, STARVE_LIMIT=4 -> grant order D,D,D,D,I,D,D,D,D,I. instr_rdata_o is zero except on instr_rvalid_o.
- Wait states: mem_gnt_i delayed 2 cycles and mem_rvalid_i delayed 3 cycles -> mem_req_o high for 3 cycles, fetch_stall_o high throughout, no second grant before IDLE.
- Reset mid-op: rst_n low while in RESP, then mem_rvalid_i arrives after release -> no rvalid_o pulses, all outputs 0, a fresh instr request is granted normally.
- Spurious rvalid: mem_rvalid_i=1 in IDLE -> both rvalid_o stay 0 and the state is unchanged.
